exc_sched: RTL and testbench
============================

# exc_sched

Exception and interrupt scheduler for the CP0 register block. It sits at the MEM/WB boundary and takes per-instruction exception flags plus the CP0 Status/Cause/EPC values. It prioritises one event per instruction, issues a one-cycle commit to CP0 with excepttype, PC, delay-slot flag and bad address, then holds a pipeline flush for a fixed number of cycles while steering the fetch PC to the handler vector or EPC.

## Interface
- FLUSH_CYCLES, 2: total cycles flush_o stays high per event; minimum 1.
- EXC_VECTOR, 32'hBFC00380: new PC for every event except ERET.
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- valid_i  in  1  MEM-stage slot holds a real instruction.
- stall_i  in  1  pipeline stalled, for example by an outstanding memory access.
- pc_i  in  32  MEM-stage instruction address.
- in_delayslot_i  in  1  instruction is in a branch delay slot.
- mem_addr_i  in  32  load/store effective address.
- adel_if_i, ri_i, ov_i, trap_i, syscall_i, break_i, adel_ld_i, ades_i, eret_i  in  1 each  exception flags.
- int_i  in  6  asynchronous hardware interrupt lines.
- timer_int_i  in  1  CP0 timer interrupt.
- status_i, cause_i, epc_i  in  32 each  current CP0 Status, Cause and EPC.
- cp0_en_o  out  1  one-cycle commit strobe to CP0.
- excepttype_o  out  32  event code.
- cur_pc_o  out  32  PC passed to CP0.
- delayslot_o  out  1  delay-slot flag passed to CP0.
- bad_addr_o  out  32  BadVAddr value.
- flush_o  out  1  flush all stages up to and including MEM.
- newpc_o  out  32  redirect PC, valid while flush_o=1.
- busy_o  out  1  state ≠ IDLE.

## Operation
- Event codes: 0x01 Int, 0x04 AdEL, 0x05 AdES, 0x08 Sys, 0x09 Bp, 0x0a RI, 0x0c Ov, 0x0d Tr, 0x0e ERET.
- Interrupt pending condition, all of the following:
  - status_i[0]=1 and status_i[1]=0.
  - ({hw[5:0], cause_i[9:8]} & status_i[15:8]) ≠ 0.
  - hw = synchronised int_i, with bit 5 ORed with timer_int_i.
- Priority, highest first: Int, AdEL (fetch), RI, Ov, Tr, Sys, Bp, AdEL (load), AdES, ERET.
- Events are considered only when valid_i=1.
- bad_addr_o:
  - AdEL (fetch): pc_i.
  - AdEL (load) and AdES: mem_addr_i.
  - All other events: 0.
- States: IDLE, WAIT, COMMIT, FLUSH.
- IDLE:
  - On an event with stall_i=0: latch event fields, go to COMMIT.
  - On an event with stall_i=1: latch, go to WAIT.
- WAIT: hold latched fields and ignore new flags. Go to COMMIT on the first cycle with stall_i=0.
- COMMIT:
  - cp0_en_o=1, flush_o=1.
  - newpc_o = epc_i (sampled this cycle) for ERET, else EXC_VECTOR.
  - Next state is FLUSH if FLUSH_CYCLES>1, else IDLE.
- FLUSH:
  - flush_o=1, newpc_o held, cp0_en_o=0.
  - Counts FLUSH_CYCLES-1 cycles, then IDLE.
  - All input flags are ignored.
- Interrupt re-evaluation: the interrupt condition is re-evaluated on the WAIT→COMMIT transition. If it cleared and no other event is latched, return to IDLE without a commit.
- Reset values: all outputs 0, state IDLE, counter 0, synchroniser flops 0. A reset mid-sequence aborts without a commit.

## Timing
- Event at cycle N in IDLE with stall_i=0:
  - cp0_en_o=1 at N+1 only.
  - flush_o=1 for N+1 … N+FLUSH_CYCLES.
  - busy_o falls at N+FLUSH_CYCLES+1.
- With a stall: the commit happens in the cycle after the first stall_i=0 cycle.
- Asynchronous int_i has 2-cycle synchroniser latency before it can trigger an event.
- Output registers: excepttype_o, cur_pc_o, delayslot_o, bad_addr_o are registered and stable COMMIT through FLUSH.
- Simultaneous flags: exactly one code is issued, chosen by priority; the rest are dropped, since the flush kills the instruction.
- Back-to-back: an event presented during FLUSH is lost. The pipeline guarantees the instruction is flushed.

## Configuration
- EXC_TRAP_EN defined: trap_i participates at its priority slot and issues 0x0d.
- EXC_TRAP_EN undefined: trap_i is ignored entirely and never affects state.

## Structure
- Shared package:
  - Excepttype code constants.
  - State enum.
  - EXC_VECTOR default.
  - Interrupt bit positions: IE=0, EXL=1, IM=15:8, IP=15:8.
- Sub-module exc_int_sync: 6-bit, 2-flop synchroniser for int_i.

## Test plan
- status=0x0000_0401, int_i[0]=1, valid_i=1:
  - After 2 sync cycles, cp0_en_o pulses with excepttype 0x01.
  - newpc=0xBFC00380, flush_o high 2 cycles.
- ov_i=1 and syscall_i=1 together, pc_i=0xBFC0_1000, in_delayslot_i=1 → single commit with excepttype 0x0c, cur_pc 0xBFC0_1000, delayslot_o=1.
- adel_ld_i=1, mem_addr_i=0x8000_0003, stall_i=1 for 3 cycles:
  - WAIT holds.
  - Commit one cycle after stall_i falls, bad_addr_o=0x8000_0003.
- eret_i=1, epc_i=0xBFC0_0200 → excepttype 0x0e, newpc_o=0xBFC0_0200.
- Reset asserted in FLUSH state: flush_o, busy_o, cp0_en_o all 0 the next cycle, state IDLE.
- trap_i=1 alone:
  - With EXC_TRAP_EN → code 0x0d.
  - Without → no commit, busy_o stays 0.

Source files
------------

// File: rtl/exc_sched_pkg.sv
// Shared definitions for the exception scheduler: event codes, FSM states,
// default handler vector, CP0 Status/Cause bit positions and the interrupt
// pending helper.
package exc_sched_pkg;

    localparam logic [31:0] EXC_VECTOR_DEF = 32'hBFC0_0380;

    localparam logic [31:0] EXC_INT  = 32'h0000_0001;
    localparam logic [31:0] EXC_ADEL = 32'h0000_0004;
    localparam logic [31:0] EXC_ADES = 32'h0000_0005;
    localparam logic [31:0] EXC_SYS  = 32'h0000_0008;
    localparam logic [31:0] EXC_BP   = 32'h0000_0009;
    localparam logic [31:0] EXC_RI   = 32'h0000_000a;
    localparam logic [31:0] EXC_OV   = 32'h0000_000c;
    localparam logic [31:0] EXC_TR   = 32'h0000_000d;
    localparam logic [31:0] EXC_ERET = 32'h0000_000e;

    localparam int unsigned ST_IE  = 0;
    localparam int unsigned ST_EXL = 1;
    localparam int unsigned IM_HI  = 15;
    localparam int unsigned IM_LO  = 8;
    localparam int unsigned IP_HI  = 15;
    localparam int unsigned IP_LO  = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_COMMIT = 2'd2,
        ST_FLUSH  = 2'd3
    } state_t;

    // Commit payload for a non-interrupt event.
    typedef struct packed {
        logic [31:0] code;
        logic [31:0] pc;
        logic [31:0] bad;
        logic        ds;
    } exc_rec_t;

    // Interrupt pending: IE set, EXL clear, and any enabled pending line.
    function automatic logic int_pending(input logic [31:0] status,
                                         input logic [31:0] cause,
                                         input logic [5:0]  hw);
        logic [7:0] ip;
        ip = {hw, cause[IP_LO+1:IP_LO]};
        return status[ST_IE] && !status[ST_EXL] &&
               ((ip & status[IM_HI:IM_LO]) != 8'd0);
    endfunction

endpackage

// File: rtl/exc_int_sync.sv
// Two-flop synchroniser for the six asynchronous hardware interrupt lines.
// Ports: clk, rst (sync, active-high), int_i[5:0] async in, int_o[5:0] synced.
module exc_int_sync (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] int_i,
    output logic [5:0] int_o
);

    logic [5:0] meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta  <= 6'd0;
            int_o <= 6'd0;
        end else begin
            meta  <= int_i;
            int_o <= meta;
        end
    end

endmodule

// File: rtl/exc_sched.sv
// Exception/interrupt scheduler at the MEM/WB boundary. Picks one event per
// instruction, issues a one-cycle CP0 commit, then holds flush_o for
// FLUSH_CYCLES cycles while steering fetch to EXC_VECTOR (or EPC for ERET).
// Ports: clk, rst (sync, active-high); MEM-stage valid/stall/pc/delay-slot/
// address and exception flags; int_i/timer_int_i; CP0 status/cause/epc in;
// cp0_en_o, excepttype_o, cur_pc_o, delayslot_o, bad_addr_o, flush_o,
// newpc_o, busy_o out (all registered).
// Config: define EXC_TRAP_EN to let trap_i raise code 0x0d.
module exc_sched
    import exc_sched_pkg::*;
#(
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter logic [31:0] EXC_VECTOR   = EXC_VECTOR_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_i,
    input  logic        stall_i,
    input  logic [31:0] pc_i,
    input  logic        in_delayslot_i,
    input  logic [31:0] mem_addr_i,
    input  logic        adel_if_i,
    input  logic        ri_i,
    input  logic        ov_i,
    input  logic        trap_i,
    input  logic        syscall_i,
    input  logic        break_i,
    input  logic        adel_ld_i,
    input  logic        ades_i,
    input  logic        eret_i,
    input  logic [5:0]  int_i,
    input  logic        timer_int_i,
    input  logic [31:0] status_i,
    input  logic [31:0] cause_i,
    input  logic [31:0] epc_i,
    output logic        cp0_en_o,
    output logic [31:0] excepttype_o,
    output logic [31:0] cur_pc_o,
    output logic        delayslot_o,
    output logic [31:0] bad_addr_o,
    output logic        flush_o,
    output logic [31:0] newpc_o,
    output logic        busy_o
);

    localparam int unsigned CNT_W = $clog2(FLUSH_CYCLES + 1);

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [5:0]         int_sync;
    logic [5:0]         hw;
    logic               int_now;
    logic               evt_found;
    exc_rec_t           evt;
    logic               lat_int;
    logic               lat_has;
    exc_rec_t           lat;
    logic               src_int;
    logic               src_has;
    exc_rec_t           cm;
    logic [31:0]        cm_newpc;

    exc_int_sync u_sync (
        .clk   (clk),
        .rst   (rst),
        .int_i (int_i),
        .int_o (int_sync)
    );

    assign hw      = {int_sync[5] | timer_int_i, int_sync[4:0]};
    assign int_now = int_pending(status_i, cause_i, hw);

`ifdef EXC_TRAP_EN
    logic unused_sink;
    assign unused_sink = &{1'b0, status_i[31:16], status_i[7:2],
                           cause_i[31:10], cause_i[7:0]};
`else
    logic unused_sink;
    assign unused_sink = &{1'b0, trap_i, status_i[31:16], status_i[7:2],
                           cause_i[31:10], cause_i[7:0]};
`endif

    // Highest-priority synchronous (non-interrupt) event of the MEM instruction.
    always_comb begin
        evt_found = 1'b1;
        evt.pc    = pc_i;
        evt.ds    = in_delayslot_i;
        evt.bad   = 32'd0;
        evt.code  = 32'd0;
        if (adel_if_i) begin
            evt.code = EXC_ADEL;
            evt.bad  = pc_i;
        end else if (ri_i) begin
            evt.code = EXC_RI;
        end else if (ov_i) begin
            evt.code = EXC_OV;
        end
`ifdef EXC_TRAP_EN
        else if (trap_i) begin
            evt.code = EXC_TR;
        end
`endif
        else if (syscall_i) begin
            evt.code = EXC_SYS;
        end else if (break_i) begin
            evt.code = EXC_BP;
        end else if (adel_ld_i) begin
            evt.code = EXC_ADEL;
            evt.bad  = mem_addr_i;
        end else if (ades_i) begin
            evt.code = EXC_ADES;
            evt.bad  = mem_addr_i;
        end else if (eret_i) begin
            evt.code = EXC_ERET;
        end else begin
            evt_found = 1'b0;
        end
    end

    // Commit payload: live inputs from IDLE, latched ones from WAIT with the
    // interrupt condition re-checked against current CP0 state.
    always_comb begin
        src_int = int_now;
        src_has = evt_found;
        cm      = evt;
        if (state == ST_WAIT) begin
            src_int = lat_int && int_now;
            src_has = lat_has;
            cm      = lat;
        end
        if (src_int) begin
            cm.code = EXC_INT;
            cm.bad  = 32'd0;
        end
        cm_newpc = (cm.code == EXC_ERET) ? epc_i : EXC_VECTOR;
    end

    // Scheduler FSM with registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            lat_int      <= 1'b0;
            lat_has      <= 1'b0;
            lat          <= '0;
            cp0_en_o     <= 1'b0;
            excepttype_o <= 32'd0;
            cur_pc_o     <= 32'd0;
            delayslot_o  <= 1'b0;
            bad_addr_o   <= 32'd0;
            flush_o      <= 1'b0;
            newpc_o      <= 32'd0;
            busy_o       <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_WAIT: begin
                    if (state == ST_IDLE && valid_i && (int_now || evt_found)) begin
                        lat_int <= int_now;
                        lat_has <= evt_found;
                        lat     <= evt;
                        busy_o  <= 1'b1;
                    end
                    if ((state == ST_IDLE && valid_i && (int_now || evt_found)) ||
                        state == ST_WAIT) begin
                        if (stall_i) begin
                            state <= ST_WAIT;
                        end else if (src_int || src_has) begin
                            state        <= ST_COMMIT;
                            cp0_en_o     <= 1'b1;
                            flush_o      <= 1'b1;
                            busy_o       <= 1'b1;
                            excepttype_o <= cm.code;
                            cur_pc_o     <= cm.pc;
                            delayslot_o  <= cm.ds;
                            bad_addr_o   <= cm.bad;
                            newpc_o      <= cm_newpc;
                        end else begin
                            // Interrupt withdrawn while stalled, nothing else pending.
                            state  <= ST_IDLE;
                            busy_o <= 1'b0;
                        end
                    end
                end
                ST_COMMIT: begin
                    cp0_en_o <= 1'b0;
                    if (FLUSH_CYCLES > 1) begin
                        state <= ST_FLUSH;
                        cnt   <= CNT_W'(FLUSH_CYCLES - 1);
                    end else begin
                        state   <= ST_IDLE;
                        flush_o <= 1'b0;
                        busy_o  <= 1'b0;
                    end
                end
                ST_FLUSH: begin
                    if (cnt <= CNT_W'(1)) begin
                        state   <= ST_IDLE;
                        cnt     <= '0;
                        flush_o <= 1'b0;
                        busy_o  <= 1'b0;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_exc_sched.sv
// Directed self-checking bench for exc_sched (FLUSH_CYCLES=2).
module tb_exc_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_i, stall_i, in_delayslot_i;
    logic [31:0] pc_i, mem_addr_i;
    logic        adel_if_i, ri_i, ov_i, trap_i, syscall_i, break_i;
    logic        adel_ld_i, ades_i, eret_i;
    logic [5:0]  int_i;
    logic        timer_int_i;
    logic [31:0] status_i, cause_i, epc_i;
    logic        cp0_en_o, delayslot_o, flush_o, busy_o;
    logic [31:0] excepttype_o, cur_pc_o, bad_addr_o, newpc_o;

    int total = 0;
    int bad   = 0;

    exc_sched #(.FLUSH_CYCLES(2), .EXC_VECTOR(32'hBFC0_0380)) dut (
        .clk(clk), .rst(rst), .valid_i(valid_i), .stall_i(stall_i),
        .pc_i(pc_i), .in_delayslot_i(in_delayslot_i), .mem_addr_i(mem_addr_i),
        .adel_if_i(adel_if_i), .ri_i(ri_i), .ov_i(ov_i), .trap_i(trap_i),
        .syscall_i(syscall_i), .break_i(break_i), .adel_ld_i(adel_ld_i),
        .ades_i(ades_i), .eret_i(eret_i), .int_i(int_i),
        .timer_int_i(timer_int_i), .status_i(status_i), .cause_i(cause_i),
        .epc_i(epc_i), .cp0_en_o(cp0_en_o), .excepttype_o(excepttype_o),
        .cur_pc_o(cur_pc_o), .delayslot_o(delayslot_o),
        .bad_addr_o(bad_addr_o), .flush_o(flush_o), .newpc_o(newpc_o),
        .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        valid_i = 0; stall_i = 0; in_delayslot_i = 0;
        pc_i = 32'h0; mem_addr_i = 32'h0;
        adel_if_i = 0; ri_i = 0; ov_i = 0; trap_i = 0; syscall_i = 0;
        break_i = 0; adel_ld_i = 0; ades_i = 0; eret_i = 0;
        int_i = 6'd0; timer_int_i = 0;
        status_i = 32'h0; cause_i = 32'h0; epc_i = 32'h0;
    endtask

    initial begin
        clr();
        rst = 1;
        step(); step();
        chk("rst_cp0",   32'(cp0_en_o), 32'h0);
        chk("rst_flush", 32'(flush_o),  32'h0);
        chk("rst_busy",  32'(busy_o),   32'h0);
        chk("rst_code",  excepttype_o,  32'h0);
        chk("rst_newpc", newpc_o,       32'h0);
        rst = 0;
        step();

        // Interrupt through the synchroniser.
        status_i = 32'h0000_0401; int_i = 6'b000001; valid_i = 1; pc_i = 32'hBFC0_0040;
        step();
        chk("int_sync1_cp0", 32'(cp0_en_o), 32'h0);
        step();
        chk("int_sync2_cp0", 32'(cp0_en_o), 32'h0);
        step();
        chk("int_cp0",   32'(cp0_en_o), 32'h1);
        chk("int_code",  excepttype_o,  32'h01);
        chk("int_newpc", newpc_o,       32'hBFC0_0380);
        chk("int_flush", 32'(flush_o),  32'h1);
        chk("int_pc",    cur_pc_o,      32'hBFC0_0040);
        clr();
        step();
        chk("int_f2_cp0",   32'(cp0_en_o), 32'h0);
        chk("int_f2_flush", 32'(flush_o),  32'h1);
        step();
        chk("int_end_flush", 32'(flush_o), 32'h0);
        chk("int_end_busy",  32'(busy_o),  32'h0);
        step();

        // Simultaneous Ov and Sys: Ov wins.
        valid_i = 1; ov_i = 1; syscall_i = 1; pc_i = 32'hBFC0_1000; in_delayslot_i = 1;
        step();
        chk("ov_cp0",  32'(cp0_en_o),    32'h1);
        chk("ov_code", excepttype_o,     32'h0c);
        chk("ov_pc",   cur_pc_o,         32'hBFC0_1000);
        chk("ov_ds",   32'(delayslot_o), 32'h1);
        chk("ov_bad",  bad_addr_o,       32'h0);
        clr();
        step(); step();
        chk("ov_idle", 32'(busy_o), 32'h0);

        // Load address error held by a stall.
        valid_i = 1; adel_ld_i = 1; mem_addr_i = 32'h8000_0003; pc_i = 32'h0000_1234; stall_i = 1;
        step();
        chk("wait1_busy", 32'(busy_o),   32'h1);
        chk("wait1_cp0",  32'(cp0_en_o), 32'h0);
        valid_i = 0; adel_ld_i = 0; ri_i = 1;
        step();
        chk("wait2_cp0", 32'(cp0_en_o), 32'h0);
        step();
        chk("wait3_cp0",   32'(cp0_en_o), 32'h0);
        chk("wait3_flush", 32'(flush_o),  32'h0);
        stall_i = 0;
        step();
        chk("adel_cp0",  32'(cp0_en_o), 32'h1);
        chk("adel_code", excepttype_o,  32'h04);
        chk("adel_bad",  bad_addr_o,    32'h8000_0003);
        clr();
        step(); step();
        chk("adel_idle", 32'(busy_o), 32'h0);

        // Fetch AdEL beats RI; bad address is the PC.
        valid_i = 1; adel_if_i = 1; ri_i = 1; pc_i = 32'h0000_0002; mem_addr_i = 32'h5555_0000;
        step();
        chk("adif_code", excepttype_o, 32'h04);
        chk("adif_bad",  bad_addr_o,   32'h0000_0002);
        clr();
        step(); step();

        // ERET redirects to EPC.
        valid_i = 1; eret_i = 1; epc_i = 32'hBFC0_0200; pc_i = 32'h0000_0100;
        step();
        chk("eret_code",  excepttype_o, 32'h0e);
        chk("eret_newpc", newpc_o,      32'hBFC0_0200);
        clr();
        step();
        chk("eret_hold", newpc_o, 32'hBFC0_0200);
        step();

        // Reset in FLUSH aborts the sequence.
        valid_i = 1; break_i = 1; pc_i = 32'h0000_0300;
        step();
        chk("bp_code", excepttype_o, 32'h09);
        clr();
        step();
        chk("bp_flush", 32'(flush_o), 32'h1);
        rst = 1;
        step();
        chk("rstf_flush", 32'(flush_o),  32'h0);
        chk("rstf_busy",  32'(busy_o),   32'h0);
        chk("rstf_cp0",   32'(cp0_en_o), 32'h0);
        rst = 0;
        step();
        chk("rstf_idle", 32'(busy_o), 32'h0);

        // Interrupt withdrawn while stalled: no commit.
        status_i = 32'h0000_0401; int_i = 6'b000001;
        step(); step();
        valid_i = 1; stall_i = 1;
        step();
        chk("iw_busy", 32'(busy_o),   32'h1);
        chk("iw_cp0",  32'(cp0_en_o), 32'h0);
        clr();
        step();
        chk("iw_cp0b",  32'(cp0_en_o), 32'h0);
        chk("iw_idle",  32'(busy_o),   32'h0);
        step();
        chk("iw_cp0c",  32'(cp0_en_o), 32'h0);
        step(); step();

        // Trap alone.
        valid_i = 1; trap_i = 1; pc_i = 32'h0000_0400;
        step();
`ifdef EXC_TRAP_EN
        chk("trap_cp0",  32'(cp0_en_o), 32'h1);
        chk("trap_code", excepttype_o,  32'h0d);
`else
        chk("trap_cp0",  32'(cp0_en_o), 32'h0);
        chk("trap_busy", 32'(busy_o),   32'h0);
`endif
        clr();
        step(); step();
        chk("trap_idle", 32'(busy_o), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
